fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 15 +
 rtl/fetch_queue_compactor.sv | 26 ++
 rtl/fetch_queue.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: entry layout, default depth, pointer/count types.
package FetchQueueTypes;

    localparam int FETCH_QUEUE_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [32:0] brPred;
    } FetchQueueEntry;

    typedef logic [$clog2(FETCH_QUEUE_DEPTH)-1:0]   fq_ptr_t;
    typedef logic [$clog2(FETCH_QUEUE_DEPTH+1)-1:0] fq_count_t;

endpackage

// File: rtl/fetch_queue_compactor.sv
// Lane compaction helper: for each fetch lane, the number of valid lanes below it
// (its write offset from tail) and the total number of valid lanes.
module fetch_queue_compactor #(
    parameter int FETCH_WIDTH = 2
) (
    input  logic [FETCH_WIDTH-1:0]                         valid_i,
    output logic [FETCH_WIDTH*$clog2(FETCH_WIDTH+1)-1:0]   lane_offset_o,
    output logic [$clog2(FETCH_WIDTH+1)-1:0]               valid_count_o
);

    localparam int OFF_W = $clog2(FETCH_WIDTH+1);

    logic [OFF_W-1:0] acc;

    // Exclusive prefix sum of the valid bits in ascending lane order.
    always_comb begin
        acc           = '0;
        lane_offset_o = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            lane_offset_o[k*OFF_W +: OFF_W] = acc;
            acc = acc + OFF_W'(valid_i[k]);
        end
        valid_count_o = acc;
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between the fetch and pre-decode stages: multi-lane push with
// compaction, multi-lane in-order pop, flush, and an optional full-stall counter.
// Optional feature macro: FETCH_QUEUE_PERF_EN (enables perf_full_cycles counting).
import FetchQueueTypes::*;

module fetch_queue #(
    parameter int FETCH_WIDTH  = 2,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = FETCH_QUEUE_DEPTH,
    parameter int ENTRY_WIDTH  = $bits(FetchQueueEntry)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [FETCH_WIDTH-1:0]              in_valid,
    input  logic [FETCH_WIDTH*ENTRY_WIDTH-1:0]  in_entry,
    output logic                                in_ready,
    input  logic                                out_stall,
    output logic [DECODE_WIDTH-1:0]             out_valid,
    output logic [DECODE_WIDTH*ENTRY_WIDTH-1:0] out_entry,
    output logic [$clog2(DEPTH+1)-1:0]          count,
    output logic [31:0]                         perf_full_cycles
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int OFF_W = $clog2(FETCH_WIDTH+1);

    logic [PTR_W-1:0]             head_q, head_d;
    logic [PTR_W-1:0]             tail_q, tail_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [ENTRY_WIDTH-1:0]       mem_q [DEPTH];

    logic [FETCH_WIDTH*OFF_W-1:0] lane_offset;
    logic [OFF_W-1:0]             valid_count;
    logic [CNT_W-1:0]             free_slots;
    logic                         push_en;
    logic                         pop_en;
    logic [CNT_W-1:0]             pushed;
    logic [CNT_W-1:0]             popped;

    fetch_queue_compactor #(
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_compactor (
        .valid_i       (in_valid),
        .lane_offset_o (lane_offset),
        .valid_count_o (valid_count)
    );

    // Readiness only looks at registered occupancy; a same-cycle pop earns no credit.
    always_comb begin
        free_slots = CNT_W'(DEPTH) - count_q;
        in_ready   = (free_slots >= CNT_W'(FETCH_WIDTH));
        push_en    = in_ready && !flush;
        pop_en     = !out_stall && !flush;
        pushed     = push_en ? CNT_W'(valid_count) : '0;
        popped     = '0;
        if (pop_en) begin
            popped = (count_q < CNT_W'(DECODE_WIDTH)) ? count_q : CNT_W'(DECODE_WIDTH);
        end
    end

    // Next pointers and occupancy; flush wins over push and pop.
    always_comb begin
        head_d  = head_q + PTR_W'(popped);
        tail_d  = tail_q + PTR_W'(pushed);
        count_d = count_q + pushed - popped;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage writes: valid lanes land packed at tail, tail+1, ... (modulo DEPTH).
    always_ff @(posedge clk) begin
        if (push_en) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (in_valid[k]) begin
                    mem_q[tail_q + PTR_W'(lane_offset[k*OFF_W +: OFF_W])] <=
                        in_entry[k*ENTRY_WIDTH +: ENTRY_WIDTH];
                end
            end
        end
    end

    // Read ports: oldest entry in lane 0, no bypass from the write side.
    always_comb begin
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            out_valid[i] = (count_q > CNT_W'(i)) && !flush;
            out_entry[i*ENTRY_WIDTH +: ENTRY_WIDTH] = mem_q[head_q + PTR_W'(i)];
        end
    end

    assign count = count_q;

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Count cycles where a valid fetch group is held off by a full queue; saturates.
    always_comb begin
        perf_d = perf_q;
        if (!in_ready && (|in_valid) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Stall counter register; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_full_cycles = perf_q;
`else
    assign perf_full_cycles = 32'd0;
`endif

endmodule
